// File: rtl/xood_load_ctrl.sv
// Operand loader for the Xoodyak core: packs a 32-bit word stream into key/nonce/AD/text
// registers, pulses start and holds operands until encdone. Optional XOOD_KEY_REUSE_EN.
module xood_load_ctrl (
    input  logic         eph1,
    input  logic         reset,
    input  logic         go,
    input  logic         opmode_in,
    input  logic         keep_key,
    input  logic [31:0]  din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         encdone,
    output logic [127:0] key,
    output logic [127:0] nonce,
    output logic [127:0] assodata,
    output logic [191:0] textin,
    output logic         opmode,
    output logic         start,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_KEY, S_LD_NONCE, S_LD_AD, S_LD_TEXT, S_START, S_WAIT
    } state_t;

    state_t         r_state;
    logic [2:0]     r_cnt;
    logic [127:0]   r_key, r_nonce, r_ad;
    logic [191:0]   r_text;
    logic           r_opmode, r_start, r_ready, r_busy;

    logic           w_accept, w_last, w_skip_key;

`ifdef XOOD_KEY_REUSE_EN
    assign w_skip_key = keep_key;
`else
    logic           w_unused_keep;
    assign w_unused_keep = keep_key;
    assign w_skip_key    = 1'b0;
`endif

    // r_ready is only ever set while in an LD_* state, so it doubles as the phase-active flag
    assign w_accept = din_valid & r_ready;
    assign w_last   = (r_state == S_LD_TEXT) ? (r_cnt == 3'd5) : (r_cnt == 3'd3);

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_key    <= '0;
            r_nonce  <= '0;
            r_ad     <= '0;
            r_text   <= '0;
            r_opmode <= 1'b0;
            r_start  <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_opmode <= opmode_in;
                        r_cnt    <= 3'd0;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= w_skip_key ? S_LD_NONCE : S_LD_KEY;
                    end
                end
                S_LD_KEY, S_LD_NONCE, S_LD_AD, S_LD_TEXT: begin
                    if (w_accept) begin
                        case (r_state)
                            S_LD_KEY:   r_key   <= {r_key[95:0], din};
                            S_LD_NONCE: r_nonce <= {r_nonce[95:0], din};
                            S_LD_AD:    r_ad    <= {r_ad[95:0], din};
                            default:    r_text  <= {r_text[159:0], din};
                        endcase
                        r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
                        if (w_last) begin
                            case (r_state)
                                S_LD_KEY:   r_state <= S_LD_NONCE;
                                S_LD_NONCE: r_state <= S_LD_AD;
                                S_LD_AD:    r_state <= S_LD_TEXT;
                                default: begin
                                    r_state <= S_START;
                                    r_ready <= 1'b0;
                                    r_start <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    if (encdone) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready = r_ready;
    assign start     = r_start;
    assign busy      = r_busy;
    assign key       = r_key;
    assign nonce     = r_nonce;
    assign assodata  = r_ad;
    assign textin    = r_text;
    assign opmode    = r_opmode;

endmodule

// File: tb/tb_xood_load_ctrl.sv
// Directed bench for xood_load_ctrl: load, stall, handshake, reset and key-reuse scenarios.
module tb_xood_load_ctrl;

    logic         eph1, reset, go, opmode_in, keep_key, din_valid, encdone;
    logic [31:0]  din;
    logic         din_ready, opmode, start, busy;
    logic [127:0] key, nonce, assodata;
    logic [191:0] textin;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K = 128'h6162636465666768696a6b6c6d6e6f70;
    localparam logic [127:0] N = 128'h303132333435363738393a3b3c3d3e3f;
    localparam logic [127:0] A = 128'h4142434445464748494a4b4c4d4e4f50;
    localparam logic [191:0] T = 192'h4142434445464748494a4b4c4d4e4f505152535455565758;

    logic [31:0] words [0:17] = '{
        32'h61626364, 32'h65666768, 32'h696a6b6c, 32'h6d6e6f70,
        32'h30313233, 32'h34353637, 32'h38393a3b, 32'h3c3d3e3f,
        32'h41424344, 32'h45464748, 32'h494a4b4c, 32'h4d4e4f50,
        32'h41424344, 32'h45464748, 32'h494a4b4c, 32'h4d4e4f50,
        32'h51525354, 32'h55565758};

    xood_load_ctrl dut (
        .eph1(eph1), .reset(reset), .go(go), .opmode_in(opmode_in), .keep_key(keep_key),
        .din(din), .din_valid(din_valid), .din_ready(din_ready), .encdone(encdone),
        .key(key), .nonce(nonce), .assodata(assodata), .textin(textin),
        .opmode(opmode), .start(start), .busy(busy));

    initial eph1 = 1'b0;
    always #5 eph1 = ~eph1;

    // Helpers below are entered and left at a falling edge.
    task automatic do_go(input logic opm, input logic kk);
        go = 1'b1; opmode_in = opm; keep_key = kk;
        @(negedge eph1);
        go = 1'b0; keep_key = 1'b0;
    endtask

    // Returns just before the rising edge that accepts the n-th word.
    task automatic feed(input int first, input int n, input bit stall, output int acc, output int cyc);
        int idx = first;
        acc = 0; cyc = 0;
        while (acc < n && cyc < 200) begin
            din_valid = stall ? ~cyc[0] : 1'b1;
            din = words[idx];
            if (din_valid && din_ready) begin acc++; idx++; end
            cyc++;
            if (acc < n) @(negedge eph1);
        end
    endtask

    task automatic finish_op();
        encdone = 1'b1;
        @(negedge eph1);
        encdone = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({din_ready, start, busy, opmode} !== 4'b0) begin errors++;
            $display("FAIL reset_ctl got %b exp 0000", {din_ready, start, busy, opmode}); end
        checks++; if ({key, nonce, assodata, textin} !== '0) begin errors++;
            $display("FAIL reset_ops got nonzero key=%h text=%h", key, textin); end
        @(negedge eph1); reset = 1'b1;
        @(negedge eph1);
    endtask

    task automatic test_encrypt();
        int acc, cyc;
        do_go(1'b0, 1'b0);
        checks++; if (din_ready !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL go_ready got rdy=%b busy=%b exp 1 1", din_ready, busy); end
        feed(0, 18, 0, acc, cyc);
        checks++; if (acc !== 18 || cyc !== 18) begin errors++;
            $display("FAIL enc_rate got acc=%0d cyc=%0d exp 18 18", acc, cyc); end
        @(negedge eph1); din_valid = 1'b0;
        checks++; if (start !== 1'b1 || din_ready !== 1'b0) begin errors++;
            $display("FAIL enc_start got start=%b rdy=%b exp 1 0", start, din_ready); end
        checks++; if (key !== K || nonce !== N || assodata !== A) begin errors++;
            $display("FAIL enc_kna got key=%h nonce=%h ad=%h", key, nonce, assodata); end
        checks++; if (textin !== T || opmode !== 1'b0) begin errors++;
            $display("FAIL enc_text got text=%h op=%b exp %h 0", textin, opmode, T); end
        @(negedge eph1);
        checks++; if (start !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL enc_wait got start=%b busy=%b exp 0 1", start, busy); end
        finish_op();
    endtask

    task automatic test_stall();
        int acc, cyc;
        do_go(1'b0, 1'b0);
        feed(0, 18, 1, acc, cyc);
        checks++; if (acc !== 18 || cyc !== 35) begin errors++;
            $display("FAIL stall_acc got acc=%0d cyc=%0d exp 18 35", acc, cyc); end
        @(negedge eph1); din_valid = 1'b0;
        checks++; if (start !== 1'b1) begin errors++;
            $display("FAIL stall_start got %b exp 1", start); end
        checks++; if (key !== K || nonce !== N || assodata !== A || textin !== T) begin errors++;
            $display("FAIL stall_ops got key=%h text=%h", key, textin); end
        @(negedge eph1);
        checks++; if (start !== 1'b0) begin errors++;
            $display("FAIL stall_pulse got %b exp 0", start); end
    endtask

    task automatic test_handshake();
        for (int i = 0; i < 10; i++) begin
            go = 1'b1; din_valid = 1'b1; din = 32'hdeadbeef;
            @(negedge eph1);
            checks++; if (din_ready !== 1'b0 || start !== 1'b0 || busy !== 1'b1) begin errors++;
                $display("FAIL wait_ctl got rdy=%b start=%b busy=%b exp 0 0 1", din_ready, start, busy); end
            checks++; if (key !== K || textin !== T || assodata !== A) begin errors++;
                $display("FAIL wait_ops got key=%h text=%h", key, textin); end
        end
        go = 1'b0; din_valid = 1'b0; encdone = 1'b1;
        @(negedge eph1);
        encdone = 1'b0;
        checks++; if (busy !== 1'b0 || din_ready !== 1'b0) begin errors++;
            $display("FAIL done_idle got busy=%b rdy=%b exp 0 0", busy, din_ready); end
        do_go(1'b0, 1'b0);
        checks++; if (busy !== 1'b1 || din_ready !== 1'b1) begin errors++;
            $display("FAIL rego got busy=%b rdy=%b exp 1 1", busy, din_ready); end
    endtask

    task automatic test_reset_midload();
        int acc, cyc;
        feed(0, 9, 0, acc, cyc);
        @(negedge eph1); din_valid = 1'b0; reset = 1'b0;
        #1;
        checks++; if ({din_ready, start, busy, opmode} !== 4'b0 || {key, nonce, assodata, textin} !== '0) begin
            errors++; $display("FAIL rst_mid got rdy=%b start=%b busy=%b key=%h", din_ready, start, busy, key); end
        @(negedge eph1);
        checks++; if (start !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL rst_hold got start=%b busy=%b exp 0 0", start, busy); end
        reset = 1'b1;
        @(negedge eph1);
        do_go(1'b1, 1'b0);
        feed(0, 18, 0, acc, cyc);
        @(negedge eph1); din_valid = 1'b0;
        checks++; if (start !== 1'b1 || acc !== 18) begin errors++;
            $display("FAIL dec_start got start=%b acc=%0d exp 1 18", start, acc); end
        checks++; if (opmode !== 1'b1 || key !== K || textin !== T) begin errors++;
            $display("FAIL dec_ops got op=%b key=%h text=%h", opmode, key, textin); end
        @(negedge eph1);
        finish_op();
    endtask

    task automatic test_key_reuse();
        int acc, cyc;
        do_go(1'b0, 1'b1);
`ifdef XOOD_KEY_REUSE_EN
        feed(4, 14, 0, acc, cyc);
        checks++; if (acc !== 14 || cyc !== 14) begin errors++;
            $display("FAIL reuse_acc got acc=%0d cyc=%0d exp 14 14", acc, cyc); end
        @(negedge eph1); din_valid = 1'b0;
`else
        feed(0, 14, 0, acc, cyc);
        @(negedge eph1); din_valid = 1'b0;
        checks++; if (start !== 1'b0 || din_ready !== 1'b1) begin errors++;
            $display("FAIL noreuse_14 got start=%b rdy=%b exp 0 1", start, din_ready); end
        feed(14, 4, 0, acc, cyc);
        @(negedge eph1); din_valid = 1'b0;
`endif
        checks++; if (start !== 1'b1) begin errors++;
            $display("FAIL reuse_start got %b exp 1", start); end
        checks++; if (key !== K || nonce !== N || assodata !== A || textin !== T) begin errors++;
            $display("FAIL reuse_ops got key=%h nonce=%h text=%h", key, nonce, textin); end
        @(negedge eph1);
        finish_op();
    endtask

    task automatic test_reset_start();
        int acc, cyc;
        do_go(1'b0, 1'b0);
        feed(0, 18, 0, acc, cyc);
        @(negedge eph1); din_valid = 1'b0;
        checks++; if (start !== 1'b1) begin errors++;
            $display("FAIL pre_kill got %b exp 1", start); end
        reset = 1'b0;
        #1;
        checks++; if (start !== 1'b0 || busy !== 1'b0 || key !== '0) begin errors++;
            $display("FAIL start_kill got start=%b busy=%b key=%h", start, busy, key); end
        @(negedge eph1); reset = 1'b1;
        @(negedge eph1);
        checks++; if (start !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL post_kill got start=%b busy=%b exp 0 0", start, busy); end
    endtask

    initial begin
        reset = 1'b0; go = 1'b0; opmode_in = 1'b0; keep_key = 1'b0;
        din = '0; din_valid = 1'b0; encdone = 1'b0;
        test_reset();
        test_encrypt();
        test_stall();
        test_handshake();
        test_reset_midload();
        test_key_reuse();
        test_reset_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
